// File: rtl/dcache_mem_responder.sv
// ---------------------------------------------------------------------------
// dcache_mem_responder : line-addressed backing memory for the data cache,
// programmable latency, one request at a time.      Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dcache_mem_responder #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [27:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              busy,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam int        DEPTH  = 2 ** ADDR_W;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                op_wr_q, op_wr_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic [15:0]         rd_cnt_q, rd_cnt_d;
  logic [15:0]         wr_cnt_q, wr_cnt_d;
  logic                commit;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[27:ADDR_W];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_wr_d  = op_wr_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    commit   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Write has priority when both strobes are high.
        if (mem_write || mem_read) begin
          op_wr_d = mem_write;
          idx_d   = mem_addr[ADDR_W-1:0];
          wdata_d = mem_wdata;
          cnt_d   = LAT_M1;
          state_d = (LATENCY == 1) ? S_READY : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_READY;
      end
      S_READY: begin
        commit  = op_wr_q;
        state_d = S_HOLD;
        if (op_wr_q) begin
          if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
        end else begin
          if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Read data is captured on the edge that enters READY and held until
    // the next read reaches READY, so the cache can sample it a cycle late.
    if (state_d == S_READY && state_q != S_READY && !op_wr_d)
      rdata_d = mem_q[idx_d];

    ready_d = (state_d == S_READY);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_wr_q  <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_wr_q  <= op_wr_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      if (commit) mem_q[idx_q] <= wdata_q;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign busy      = busy_q;
  assign rd_count  = rd_cnt_q;
  assign wr_count  = wr_cnt_q;

endmodule

`default_nettype wire
